// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction-fetch front end with in-order request pipelining
// and a prefetch queue of {pc, instruction} pairs feeding decode.
// Ports:
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_stall             decode not ready, hold the output register
//   i_flush             replace the next output with a NOP (no redirect)
//   i_jump, i_jump_addr redirect fetch to i_jump_addr
//   or_inst_req         request valid (combinational)
//   or_inst_req_addr    request address (fetch PC)
//   i_inst_gnt          memory accepts the request this cycle
//   i_inst_ack          in-order response valid
//   i_inst_data         response instruction word
//   or_inst_data        instruction to decode
//   or_pc               PC of or_inst_data
//   or_valid            or_inst_data is a real fetched instruction
module fetch_prefetch #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_jump,
    input  logic [XLEN-1:0] i_jump_addr,
    output logic            or_inst_req,
    output logic [XLEN-1:0] or_inst_req_addr,
    input  logic            i_inst_gnt,
    input  logic            i_inst_ack,
    input  logic [31:0]     i_inst_data,
    output logic [31:0]     or_inst_data,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] rpc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [OW-1:0]   out_after_ack;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] q_pc   [QUEUE_DEPTH];
    logic [31:0]     q_data [QUEUE_DEPTH];
    logic            issue;
    logic            ack_v;
    logic            push;
    logic            pop;

    // Each in-flight request reserves a queue slot, so a push never overflows.
    // Reset gating keeps the request low while the block is held in reset.
    assign or_inst_req = i_rst_n && !i_jump
                         && (outstanding < OW'(MAX_OUTSTANDING))
                         && ((int'(count) + int'(outstanding)) < QUEUE_DEPTH);
    assign or_inst_req_addr = fpc;

    assign issue = or_inst_req && i_inst_gnt;
    assign ack_v = i_inst_ack && (outstanding != '0);
    assign push  = ack_v && (discard == '0) && !i_jump;
    assign pop   = !i_jump && !i_stall && !i_flush && (count != '0);

    // A same-cycle ack is already retired, so it is not counted as stale.
    assign out_after_ack = outstanding - OW'(ack_v);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            outstanding <= out_after_ack + OW'(issue);
            if (i_jump) begin
                fpc     <= i_jump_addr;
                rpc     <= i_jump_addr;
                discard <= out_after_ack;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
            end else begin
                if (issue)
                    fpc <= fpc + XLEN'(4);
                if (push) begin
                    rpc    <= rpc + XLEN'(4);
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (ack_v && (discard != '0))
                    discard <= discard - 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= rpc;
            q_data[wr_ptr] <= i_inst_data;
        end
    end

    // Flush and an empty queue both fall out of the !pop path: NOP, pc kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            or_inst_data <= NOP;
            or_pc        <= RESET_PC;
            or_valid     <= 1'b0;
        end else if (i_jump) begin
            or_inst_data <= NOP;
            or_pc        <= i_jump_addr;
            or_valid     <= 1'b0;
        end else if (!i_stall) begin
            or_inst_data <= pop ? q_data[rd_ptr] : NOP;
            or_pc        <= pop ? q_pc[rd_ptr] : or_pc;
            or_valid     <= pop;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed bench for fetch_prefetch with an in-order memory
// model (data = address) and a scoreboard of expected output PCs.
module tb_fetch_prefetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        jump;
    logic [31:0] jump_addr;
    logic        req;
    logic [31:0] req_addr;
    logic        gnt;
    logic        ack;
    logic [31:0] idata;
    logic [31:0] odata;
    logic [31:0] opc;
    logic        ovalid;

    logic        gnt_en;
    logic        ack_en;
    logic [31:0] pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_fpc;
    logic [31:0] last_pc;
    int          n_out;
    int          n_mark;
    int          errors = 0;
    int          checks = 0;

    fetch_prefetch dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_jump          (jump),
        .i_jump_addr     (jump_addr),
        .or_inst_req     (req),
        .or_inst_req_addr(req_addr),
        .i_inst_gnt      (gnt),
        .i_inst_ack      (ack),
        .i_inst_data     (idata),
        .or_inst_data    (odata),
        .or_pc           (opc),
        .or_valid        (ovalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. The caller sets
    // stall/flush/jump beforehand; the memory model drives gnt/ack here.
    task automatic cyc();
        logic        fire;
        logic        was_stall;
        logic        was_jump;
        logic [31:0] a;
        logic [31:0] e;
        gnt   = gnt_en;
        ack   = ack_en && (pend.size() != 0);
        idata = ack ? pend[0] : 32'h0;
        #1;
        fire      = req && gnt;
        a         = req_addr;
        was_stall = stall;
        was_jump  = jump;
        if (fire)
            chk("req_addr", a, model_fpc);
        @(posedge clk);
        #1;
        if (ack)
            void'(pend.pop_front());
        if (was_jump) begin
            exp_q.delete();
            model_fpc = jump_addr;
        end else if (fire) begin
            pend.push_back(a);
            exp_q.push_back(model_fpc);
            model_fpc = model_fpc + 32'd4;
        end
        if (!was_jump && !was_stall && ovalid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk("out_pc", opc, e);
            chk("out_data", odata, e);
            last_pc = e;
            n_out++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; jump = 1'b0; jump_addr = '0;
        gnt = 1'b0; ack = 1'b0; idata = '0; gnt_en = 1'b1; ack_en = 1'b1;
        model_fpc = '0; last_pc = '0; n_out = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(ovalid), 32'd0);
        chk("rst_pc", opc, 32'h0);
        chk("rst_data", odata, NOP);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // first valid three edges after release, then one per cycle
        cyc(); chk("lat_e1", 32'(ovalid), 32'd0);
        cyc(); chk("lat_e2", 32'(ovalid), 32'd0);
        cyc(); chk("lat_e3", 32'(ovalid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(); chk("stream_valid", 32'(ovalid), 32'd1);
        end

        // stall: outputs frozen, requests throttle once the queue is reserved
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_pc", opc, last_pc);
            chk("stall_valid", 32'(ovalid), 32'd1);
        end
        chk("stall_req_drop", 32'(req), 32'd0);
        stall = 1'b0;
        repeat (8) cyc();

        // flush: one NOP bubble, queued instruction follows
        flush = 1'b1;
        cyc();
        chk("flush_valid", 32'(ovalid), 32'd0);
        chk("flush_data", odata, NOP);
        chk("flush_pc", opc, last_pc);
        flush = 1'b0;
        cyc(); chk("after_flush_valid", 32'(ovalid), 32'd1);
        repeat (3) cyc();

        // jump with two requests outstanding, combined with stall
        ack_en = 1'b0;
        repeat (2) cyc();
        jump = 1'b1; jump_addr = 32'h100; stall = 1'b1;
        #1 chk("jump_req", 32'(req), 32'd0);
        cyc();
        chk("jump_valid", 32'(ovalid), 32'd0);
        chk("jump_pc", opc, 32'h100);
        chk("jump_data", odata, NOP);
        jump = 1'b0; stall = 1'b0; ack_en = 1'b1;
        n_mark = n_out;
        repeat (10) cyc();
        chk("jump_outputs", 32'(n_out - n_mark), 32'd7);

        // jump in the same cycle as an ack
        jump = 1'b1; jump_addr = 32'h200;
        cyc();
        chk("jump2_pc", opc, 32'h200);
        chk("jump2_valid", 32'(ovalid), 32'd0);
        jump = 1'b0;
        n_mark = n_out;
        repeat (6) cyc();
        chk("jump2_outputs", 32'(n_out - n_mark), 32'd4);

        // asynchronous reset mid-stream with two outstanding
        ack_en = 1'b0;
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", 32'(req), 32'd0);
        chk("mrst_valid", 32'(ovalid), 32'd0);
        chk("mrst_pc", opc, 32'h0);
        chk("mrst_data", odata, NOP);
        pend.delete(); exp_q.delete(); model_fpc = '0;
        ack = 1'b0; gnt = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); chk("mrst_e1", 32'(ovalid), 32'd0);
        cyc(); chk("mrst_e2", 32'(ovalid), 32'd0);
        cyc(); chk("mrst_e3", 32'(ovalid), 32'd1);
        chk("mrst_first_pc", opc, 32'h0);
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction-fetch front end with a prefetch queue. It replaces the single-request fetch stage, which stalls the pipeline on every instruction. It keeps up to MAX_OUTSTANDING in-order memory requests in flight and buffers up to QUEUE_DEPTH fetched instructions with their PCs. It presents one instruction per cycle to decode and handles jump redirects by discarding stale in-flight responses.

## Interface
- XLEN, 32: address/PC width.
- RESET_PC, 0: first fetch address after reset.
- QUEUE_DEPTH, 4: instruction queue entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2: max granted-but-unacknowledged requests; 1..QUEUE_DEPTH.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_stall  in  1  decode not ready; hold output register.
- i_flush  in  1  replace next output with NOP; does not redirect.
- i_jump  in  1  redirect fetch to i_jump_addr.
- i_jump_addr  in  XLEN  redirect target.
- or_inst_req  out  1  request valid.
- or_inst_req_addr  out  XLEN  request address (fetch PC).
- i_inst_gnt  in  1  memory accepts request this cycle.
- i_inst_ack  in  1  response valid; responses return in request order.
- i_inst_data  in  32  response instruction word.
- or_inst_data  out  32  instruction to decode.
- or_pc  out  XLEN  PC of or_inst_data.
- or_valid  out  1  or_inst_data is a real fetched instruction.

## Operation
- State:
  - fpc: next request address.
  - rpc: PC of the next non-discarded response.
  - outstanding counter, width clog2(MAX_OUTSTANDING+1).
  - discard counter, same width.
  - circular queue of {pc, data} with rd/wr pointers and count.
  - output register.
- Issue: or_inst_req = !i_jump && outstanding < MAX_OUTSTANDING && (count + outstanding) < QUEUE_DEPTH. or_inst_req_addr = fpc.
  - On or_inst_req && i_inst_gnt: fpc += 4 (wraps modulo 2^XLEN) and outstanding++.
- Response: on i_inst_ack, outstanding--.
  - If discard > 0: drop the data and discard--.
  - Otherwise push {rpc, i_inst_data} and rpc += 4.
  - An ack with outstanding == 0 is ignored.
- No overflow: the issue rule reserves a queue slot per request, so a push never finds the queue full, including a simultaneous push and pop at count == QUEUE_DEPTH-1.
- Jump (highest priority):
  - fpc = rpc = i_jump_addr.
  - Queue cleared.
  - discard = outstanding after this cycle's ack, so same-cycle acks are counted.
  - No request is issued in the jump cycle.
  - The output register loads NOP (0x00000013), or_valid = 0, or_pc = i_jump_addr. This overrides i_stall.
- Output register, when not jumping:
  - i_stall: hold all outputs; no pop.
  - else i_flush: load NOP, or_valid = 0, or_pc unchanged; no pop.
  - else queue non-empty: pop head into or_inst_data/or_pc, or_valid = 1.
  - else: NOP, or_valid = 0, or_pc unchanged.
- Reset:
  - fpc = rpc = RESET_PC.
  - Counters, pointers, count = 0.
  - or_inst_data = 0x00000013, or_pc = RESET_PC, or_valid = 0.
  - or_inst_req = 0 while i_rst_n is low.
- Reset mid-operation: all in-flight requests are forgotten. Memory is reset together with this block, so no late acks arrive.

## Timing
- or_inst_req and or_inst_req_addr are combinational from registered state and i_jump only. They are independent of i_inst_gnt.
- Minimum latency: grant at edge N, ack at edge N+1 (push), or_valid = 1 after edge N+2. There is no queue bypass.
- Sustained throughput is one instruction per cycle when the memory grants every cycle and acks one cycle after grant, with MAX_OUTSTANDING ≥ 2.
- A jump takes effect at its edge. The first request to i_jump_addr is in the next cycle. A response to the target appears on the outputs no earlier than 3 cycles after the jump edge, after all pre-jump responses are discarded.
- i_flush and i_stall are sampled only at the clock edge; there are no asynchronous paths except i_rst_n.

## Test plan
- Reset release, gnt always 1, ack 1 cycle after gnt, memory word = address: PCs 0,4,8,… each with or_valid = 1; first or_valid rises 3 edges after reset release; thereafter one instruction per cycle.
- Hold i_stall high for 10 cycles with gnt/ack active: outputs frozen; or_inst_req drops once count + outstanding = 4; after release, the sequence resumes with no PC skipped or duplicated.
- Jump to 0x100 with 2 requests outstanding: those 2 acks are dropped; the next or_valid instruction has or_pc = 0x100 and data 0x100; a jump asserted together with i_stall forces or_valid = 0.
- Jump in the same cycle as an ack: discard count excludes that ack; no stale PC ever appears with or_valid = 1.
- i_flush for one cycle with a non-empty queue: one NOP with or_valid = 0, then the queued instruction (not lost).
- Assert i_rst_n low mid-stream with 2 outstanding: immediate or_inst_req = 0, or_valid = 0, or_pc = RESET_PC; fetching restarts from RESET_PC.
